nmos_phase_sequencer: RTL and testbench
=======================================

// Module: nmos_phase_sequencer
// PURPOSE
//  Generates the non-overlapping two-phase strobes C1 (PHI1) and C2 (PHI2) from main_clk
//  for NMOS register/DFF chains, plus the chain's global reset (sys_rst).
//  Provides a power-on init sequence, free-run and single-step modes, and programmable
//  phase and gap lengths. Sits between the clock generator and every NMOS_* cell group.
// PARAMETERS
//  CNT_W        8   width of phase/gap length config and internal timer
//  DEF_PH_LEN   4   phase-high length (main_clk cycles) after reset
//  DEF_GAP      1   non-overlap gap length (main_clk cycles) after reset
//  INIT_CYCLES  2   full PHI1/PHI2 cycles run with sys_rst=1 after reset
// PORTS
//  main_clk    in   1      master simulation clock; all state on posedge
//  R           in   1      asynchronous, active-high reset
//  cfg_ph_len  in   CNT_W  requested phase-high length
//  cfg_gap     in   CNT_W  requested gap length
//  cfg_load    in   1      capture cfg_ph_len/cfg_gap into shadow regs
//  run         in   1      level: free-running cycles while high
//  step_req    in   1      one-cycle pulse: run exactly one full cycle from IDLE
//  step_ack    out  1      one-cycle pulse when a stepped cycle completes
//  C1          out  1      PHI1 level to cells
//  C2          out  1      PHI2 level to cells
//  sys_rst     out  1      reset level to cells (drives their R input)
//  busy        out  1      high whenever state != IDLE
//  cycle_cnt   out  16     completed post-init cycles, wraps 0xFFFF->0
// BEHAVIOUR
//  - All outputs registered. R=1 (async): C1=C2=0, step_ack=0, sys_rst=1, busy=1,
//    cycle_cnt=0, shadow+active cfg = DEF_*, state=INIT at phase PH1 start.
//  - States: INIT, IDLE, PH1, GAP1, PH2, GAP2. One cycle = PH1>GAP1>PH2>GAP2.
//  - PH1: C1=1 for ph_len clocks; GAP1: C1=C2=0 for gap clocks; PH2: C2=1 ph_len clocks;
//    GAP2: both 0 for gap clocks. Period = 2*(ph_len+gap). C1&C2 never both 1.
//  - Length 0 in cfg treated as 1 (both ph_len and gap); gap>=1 guarantees non-overlap.
//  - cfg_load: shadow regs updated next edge, any state. Active regs copy shadow only
//    on entry to PH1 (cycle boundary); a running phase is never resized.
//  - INIT: runs INIT_CYCLES full cycles with sys_rst=1; sys_rst drops to 0 on the edge
//    leaving the last GAP2. Then PH1 if run=1, else IDLE. INIT cycles not counted.
//  - IDLE: C1=C2=0. run=1 -> PH1 next edge. step_req=1 (run=0) -> PH1, step mode.
//    run and step_req together: run wins, no step_ack.
//  - run dropped mid-cycle: current cycle completes through GAP2, then IDLE.
//  - step mode: after GAP2 -> IDLE, step_ack=1 for exactly one clock; step_req
//    while not IDLE ignored (no ack, no queueing).
//  - cycle_cnt += 1 at each GAP2 exit outside INIT.
//  - R asserted mid-phase: C1/C2 drop immediately (async); full INIT reruns.
// STRUCTURE
//  - Include nmos_phase_pkg.vh: state encodings (ST_INIT..ST_GAP2), DEF_* defaults.
//  - Sub-module nmos_phase_timer: loadable CNT_W down-counter, load value, 'done' at 0;
//    FSM reloads it with ph_len-1 / gap-1 on every state entry.
// TESTING
//  1. R pulse, run=0, defaults -> sys_rst=1 for 2*2*(4+1)=20 clocks, then IDLE, C1=C2=0.
//  2. run=1, ph_len=4, gap=1 -> C1 high 4, low 1, C2 high 4, low 1; period 10; cycle_cnt
//     +1 per period; assert !(C1&C2) every clock.
//  3. cfg_load ph_len=2,gap=3 during PH2 -> current cycle unchanged; next PH1 length 2,
//     gaps 3, period 10.
//  4. IDLE, step_req pulse -> exactly one cycle (10 clocks), step_ack one clock after
//     GAP2, busy low; second step_req mid-cycle ignored.
//  5. run fell in GAP1 -> PH2 and GAP2 still complete, then IDLE; cycle_cnt +1.
//  6. R asserted in PH1 mid-count -> C1=0 same time step, sys_rst=1, INIT restarts;
//     cfg_ph_len=0/cfg_gap=0 loaded -> behaves as 1/1, period 4.

Source files
------------

// File: rtl/nmos_phase_pkg.sv
// Shared state encodings and power-on defaults for the NMOS two-phase sequencer.
package nmos_phase_pkg;

  localparam int CNT_W       = 8;
  localparam int DEF_PH_LEN  = 4;
  localparam int DEF_GAP     = 1;
  localparam int INIT_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PH1,
    ST_GAP1,
    ST_PH2,
    ST_GAP2
  } phase_state_t;

endpackage

// File: rtl/nmos_phase_timer.sv
// Loadable down-counter that times one phase or gap; done is high once the count reaches zero.
module nmos_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             main_clk,
  input  logic             R,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge main_clk or posedge R) begin
    if (R) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/nmos_phase_sequencer.sv
// Non-overlapping PHI1/PHI2 strobe generator with power-on init, free-run and single-step modes.
module nmos_phase_sequencer
  import nmos_phase_pkg::*;
#(
  parameter int CNT_W       = nmos_phase_pkg::CNT_W,
  parameter int DEF_PH_LEN  = nmos_phase_pkg::DEF_PH_LEN,
  parameter int DEF_GAP     = nmos_phase_pkg::DEF_GAP,
  parameter int INIT_CYCLES = nmos_phase_pkg::INIT_CYCLES
) (
  input  logic             main_clk,
  input  logic             R,
  input  logic [CNT_W-1:0] cfg_ph_len,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic             cfg_load,
  input  logic             run,
  input  logic             step_req,
  output logic             step_ack,
  output logic             C1,
  output logic             C2,
  output logic             sys_rst,
  output logic             busy,
  output logic [15:0]      cycle_cnt
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  // A programmed length of zero behaves as one clock so the gap always separates the phases.
  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  phase_state_t     state, nxt;
  logic             in_init, step_mode;
  logic [INIT_W-1:0] init_cnt;
  logic [CNT_W-1:0] shadow_ph, shadow_gap, act_ph, act_gap;
  logic             tmr_load, tmr_done, cycle_end, last_init;
  logic [CNT_W-1:0] tmr_val;

  assign cycle_end = (state == ST_GAP2) && tmr_done;
  assign last_init = (init_cnt == INIT_W'(INIT_CYCLES - 1));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    nxt     = state;
    tmr_val = '0;
    case (state)
      ST_INIT: nxt = ST_PH1;
      ST_IDLE: if (run || step_req) nxt = ST_PH1;
      ST_PH1:  if (tmr_done) nxt = ST_GAP1;
      ST_GAP1: if (tmr_done) nxt = ST_PH2;
      ST_PH2:  if (tmr_done) nxt = ST_GAP2;
      ST_GAP2: begin
        if (tmr_done) begin
          if (in_init) nxt = (!last_init || run) ? ST_PH1 : ST_IDLE;
          else         nxt = (run && !step_mode) ? ST_PH1 : ST_IDLE;
        end
      end
      default: nxt = ST_INIT;
    endcase
    // Every state entry is a state change; PH1 entry times itself from the shadow it is about to adopt.
    tmr_load = (nxt != state);
    case (nxt)
      ST_PH1:           tmr_val = eff_len(shadow_ph) - CNT_W'(1);
      ST_PH2:           tmr_val = act_ph - CNT_W'(1);
      ST_GAP1, ST_GAP2: tmr_val = act_gap - CNT_W'(1);
      default:          tmr_val = '0;
    endcase
  end

  always_ff @(posedge main_clk or posedge R) begin
    if (R) begin
      state      <= ST_INIT;
      in_init    <= 1'b1;
      init_cnt   <= '0;
      step_mode  <= 1'b0;
      shadow_ph  <= CNT_W'(DEF_PH_LEN);
      shadow_gap <= CNT_W'(DEF_GAP);
      act_ph     <= CNT_W'(DEF_PH_LEN);
      act_gap    <= CNT_W'(DEF_GAP);
      C1         <= 1'b0;
      C2         <= 1'b0;
      sys_rst    <= 1'b1;
      busy       <= 1'b1;
      step_ack   <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      state    <= nxt;
      C1       <= (nxt == ST_PH1);
      C2       <= (nxt == ST_PH2);
      busy     <= (nxt != ST_IDLE);
      step_ack <= 1'b0;

      if (cfg_load) begin
        shadow_ph  <= cfg_ph_len;
        shadow_gap <= cfg_gap;
      end
      // Active lengths change only at a cycle boundary, never inside a running phase.
      if (nxt == ST_PH1 && state != ST_PH1) begin
        act_ph  <= eff_len(shadow_ph);
        act_gap <= eff_len(shadow_gap);
      end
      if (state == ST_IDLE && nxt == ST_PH1) step_mode <= !run;

      if (cycle_end) begin
        if (in_init) begin
          if (last_init) begin
            in_init  <= 1'b0;
            sys_rst  <= 1'b0;
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + INIT_W'(1);
          end
        end else begin
          cycle_cnt <= cycle_cnt + 16'd1;
          if (step_mode) begin
            step_ack  <= 1'b1;
            step_mode <= 1'b0;
          end
        end
      end
    end
  end

  nmos_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .main_clk (main_clk),
    .R        (R),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

endmodule

// File: tb/tb_nmos_phase_sequencer.sv
// Directed scoreboard bench: per-clock expected strobe/status vectors are queued as stimulus is planned.
module tb_nmos_phase_sequencer;

  logic        main_clk = 1'b0;
  logic        R = 1'b0;
  logic [7:0]  cfg_ph_len = 8'd4;
  logic [7:0]  cfg_gap = 8'd1;
  logic        cfg_load = 1'b0;
  logic        run = 1'b0;
  logic        step_req = 1'b0;
  logic        step_ack, C1, C2, sys_rst, busy;
  logic [15:0] cycle_cnt;

  typedef struct packed {
    logic        c1;
    logic        c2;
    logic        srst;
    logic        busy;
    logic        ack;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt = 16'd0;
  string       step_tag = "init";

  always #5 main_clk = ~main_clk;

  nmos_phase_sequencer dut (
    .main_clk   (main_clk),
    .R          (R),
    .cfg_ph_len (cfg_ph_len),
    .cfg_gap    (cfg_gap),
    .cfg_load   (cfg_load),
    .run        (run),
    .step_req   (step_req),
    .step_ack   (step_ack),
    .C1         (C1),
    .C2         (C2),
    .sys_rst    (sys_rst),
    .busy       (busy),
    .cycle_cnt  (cycle_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic c1, input logic c2, input logic srst, input logic bsy, input logic ack);
    exp_t e;
    e.c1 = c1; e.c2 = c2; e.srst = srst; e.busy = bsy; e.ack = ack; e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  // One full PH1/GAP1/PH2/GAP2 cycle; cycles outside init bump the count seen after GAP2.
  task automatic push_cycle(input int ph, input int gap, input logic srst);
    for (int i = 0; i < ph; i++)  push(1'b1, 1'b0, srst, 1'b1, 1'b0);
    for (int i = 0; i < gap; i++) push(1'b0, 1'b0, srst, 1'b1, 1'b0);
    for (int i = 0; i < ph; i++)  push(1'b0, 1'b1, srst, 1'b1, 1'b0);
    for (int i = 0; i < gap; i++) push(1'b0, 1'b0, srst, 1'b1, 1'b0);
    if (!srst) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic push_idle(input int n, input logic ack_first);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0, (i == 0) ? ack_first : 1'b0);
  endtask

  task automatic drain(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge main_clk);
      check({step_tag, "_no_overlap"}, 32'(C1 & C2), 32'd0);
      check({step_tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({step_tag, "_sample"}, 32'({C1, C2, sys_rst, busy, step_ack, cycle_cnt}), 32'(e));
      end
    end
  endtask

  initial begin
    #1 R = 1'b1;
    repeat (2) @(negedge main_clk);
    check("rst_outputs", 32'({C1, C2, sys_rst, busy, step_ack, cycle_cnt}), 32'({5'b00110, 16'd0}));

    // Power-on init with defaults 4/1: two cycles under sys_rst, then IDLE.
    R = 1'b0;
    push_cycle(4, 1, 1'b1);
    push_cycle(4, 1, 1'b1);
    push_idle(1, 1'b0);
    drain(21);

    // Free run at 4/1, period 10.
    step_tag = "run";
    run = 1'b1;
    push_cycle(4, 1, 1'b0);
    push_cycle(4, 1, 1'b0);
    drain(20);

    // Reload 2/3 during PH2: current cycle untouched, next cycle adopts it.
    step_tag = "reload";
    push_cycle(4, 1, 1'b0);
    drain(6);
    cfg_ph_len = 8'd2; cfg_gap = 8'd3; cfg_load = 1'b1;
    drain(1);
    cfg_load = 1'b0;
    drain(3);
    push_cycle(2, 3, 1'b0);
    drain(10);

    // run drops in GAP1: cycle finishes, then IDLE.
    step_tag = "run_drop";
    push_cycle(2, 3, 1'b0);
    drain(3);
    run = 1'b0;
    drain(7);
    push_idle(3, 1'b0);
    drain(3);

    // Single step with a second request mid-cycle that must be ignored.
    step_tag = "step";
    step_req = 1'b1;
    push_cycle(2, 3, 1'b0);
    drain(1);
    step_req = 1'b0;
    drain(4);
    step_req = 1'b1;
    drain(1);
    step_req = 1'b0;
    drain(4);
    push_idle(3, 1'b1);
    drain(3);

    // run and step_req together: run wins, no acknowledge.
    step_tag = "run_step";
    run = 1'b1; step_req = 1'b1;
    push_cycle(2, 3, 1'b0);
    drain(1);
    run = 1'b0; step_req = 1'b0;
    drain(9);
    push_idle(2, 1'b0);
    drain(2);

    // Reset mid-PH1 drops the strobes at once and reruns init.
    step_tag = "mid_reset";
    run = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drain(1);
    #2 R = 1'b1;
    run = 1'b0;
    #1;
    check("async_c1", 32'(C1), 32'd0);
    check("async_sys_rst", 32'(sys_rst), 32'd1);
    check("async_busy", 32'(busy), 32'd1);
    check("async_cnt", 32'(cycle_cnt), 32'd0);
    exp_cnt = 16'd0;
    @(negedge main_clk);
    check("sb_empty_at_reset", 32'(sb.size()), 32'd0);

    // Zero lengths loaded as init starts: first init cycle keeps defaults, later cycles run 1/1.
    step_tag = "zero_cfg";
    R = 1'b0;
    cfg_ph_len = 8'd0; cfg_gap = 8'd0; cfg_load = 1'b1;
    push_cycle(4, 1, 1'b1);
    push_cycle(1, 1, 1'b1);
    push_idle(1, 1'b0);
    drain(1);
    cfg_load = 1'b0;
    drain(14);
    run = 1'b1;
    push_cycle(1, 1, 1'b0);
    drain(1);
    run = 1'b0;
    drain(3);
    push_idle(2, 1'b0);
    drain(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
